// File: rtl/alu_mdu.sv
// Iterative multiply/divide unit with private HI/LO for the MIPS EX stage.
// Define MDU_DIV_EN to compile in the restoring divider and div/divu decode.
module alu_mdu #(
   parameter int NB_DATA        = 32,
   parameter int NB_ALU_OP      = 2,
   parameter int NB_INSTRUCCION = 6
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic                      i_valid,
   input  logic [NB_ALU_OP-1:0]      i_alu_op,
   input  logic [NB_INSTRUCCION-1:0] i_inst_funcion,
   input  logic [NB_DATA-1:0]        i_dato_a,
   input  logic [NB_DATA-1:0]        i_dato_b,
   output logic [NB_DATA-1:0]        o_resultado,
   output logic [NB_DATA-1:0]        o_hi,
   output logic [NB_DATA-1:0]        o_lo,
   output logic                      o_busy,
   output logic                      o_stall
);

   localparam int CNT_W = $clog2(NB_DATA);
   localparam logic [NB_INSTRUCCION-1:0] F_MULT  = NB_INSTRUCCION'(6'b011000);
   localparam logic [NB_INSTRUCCION-1:0] F_MULTU = NB_INSTRUCCION'(6'b011001);
   localparam logic [NB_INSTRUCCION-1:0] F_MFHI  = NB_INSTRUCCION'(6'b010000);
   localparam logic [NB_INSTRUCCION-1:0] F_MTHI  = NB_INSTRUCCION'(6'b010001);
   localparam logic [NB_INSTRUCCION-1:0] F_MFLO  = NB_INSTRUCCION'(6'b010010);
   localparam logic [NB_INSTRUCCION-1:0] F_MTLO  = NB_INSTRUCCION'(6'b010011);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

   state_t                 state_q;
   logic [NB_DATA-1:0]     hi_q, lo_q, opnd_q;
   logic [2*NB_DATA-1:0]   acc_q, acc_d, prod;
   logic [CNT_W-1:0]       cnt_q;
   logic                   neg_a_q, neg_b_q, busy_q;
   logic [NB_DATA:0]       mul_sum;
   logic [NB_DATA-1:0]     fix_hi_d, fix_lo_d, a_mag, b_mag;

   logic dec_en, op_mult, op_multu, op_div, op_divu;
   logic op_mfhi, op_mthi, op_mflo, op_mtlo, op_start, op_sgn, op_any;

   assign dec_en   = i_valid && (i_alu_op == NB_ALU_OP'(2'b10));
   assign op_mult  = dec_en && (i_inst_funcion == F_MULT);
   assign op_multu = dec_en && (i_inst_funcion == F_MULTU);
   assign op_mfhi  = dec_en && (i_inst_funcion == F_MFHI);
   assign op_mthi  = dec_en && (i_inst_funcion == F_MTHI);
   assign op_mflo  = dec_en && (i_inst_funcion == F_MFLO);
   assign op_mtlo  = dec_en && (i_inst_funcion == F_MTLO);
`ifdef MDU_DIV_EN
   logic                 is_div_q;
   logic [NB_DATA:0]     div_sh, div_diff;
   assign op_div   = dec_en && (i_inst_funcion == NB_INSTRUCCION'(6'b011010));
   assign op_divu  = dec_en && (i_inst_funcion == NB_INSTRUCCION'(6'b011011));
`else
   assign op_div   = 1'b0;
   assign op_divu  = 1'b0;
`endif
   assign op_start = op_mult || op_multu || op_div || op_divu;
   assign op_sgn   = op_mult || op_div;
   assign op_any   = op_start || op_mfhi || op_mthi || op_mflo || op_mtlo;

   assign o_stall  = op_any && (state_q != S_IDLE);
   assign o_busy   = busy_q;
   assign o_hi     = hi_q;
   assign o_lo     = lo_q;

   assign a_mag = (op_sgn && i_dato_a[NB_DATA-1]) ? -i_dato_a : i_dato_a;
   assign b_mag = (op_sgn && i_dato_b[NB_DATA-1]) ? -i_dato_b : i_dato_b;

   always_comb begin
      o_resultado = '0;
      if (op_mfhi)      o_resultado = hi_q;
      else if (op_mflo) o_resultado = lo_q;
   end

   // acc_q holds {partial product, multiplier} or {remainder, dividend/quotient}
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*NB_DATA-1:NB_DATA]} + {1'b0, opnd_q};
      acc_d    = acc_q[0] ? {mul_sum, acc_q[NB_DATA-1:1]} : {1'b0, acc_q[2*NB_DATA-1:1]};
      prod     = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
      fix_hi_d = prod[2*NB_DATA-1:NB_DATA];
      fix_lo_d = prod[NB_DATA-1:0];
`ifdef MDU_DIV_EN
      div_sh   = {acc_q[2*NB_DATA-1:NB_DATA], acc_q[NB_DATA-1]};
      div_diff = div_sh - {1'b0, opnd_q};
      if (is_div_q) begin
         if (div_sh >= {1'b0, opnd_q})
            acc_d = {div_diff[NB_DATA-1:0], acc_q[NB_DATA-2:0], 1'b1};
         else
            acc_d = {div_sh[NB_DATA-1:0], acc_q[NB_DATA-2:0], 1'b0};
         // Zero divisor: quotient forced to ones; remainder naturally restores the dividend
         fix_lo_d = (opnd_q == '0) ? '1 :
                    ((neg_a_q ^ neg_b_q) ? -acc_q[NB_DATA-1:0] : acc_q[NB_DATA-1:0]);
         fix_hi_d = neg_a_q ? -acc_q[2*NB_DATA-1:NB_DATA] : acc_q[2*NB_DATA-1:NB_DATA];
      end
`endif
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= S_IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
         acc_q   <= '0;
         opnd_q  <= '0;
         cnt_q   <= '0;
         neg_a_q <= 1'b0;
         neg_b_q <= 1'b0;
         busy_q  <= 1'b0;
`ifdef MDU_DIV_EN
         is_div_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (op_start) begin
                  neg_a_q <= op_sgn && i_dato_a[NB_DATA-1];
                  neg_b_q <= op_sgn && i_dato_b[NB_DATA-1];
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_RUN;
                  if (op_mult || op_multu) begin
                     opnd_q <= a_mag;
                     acc_q  <= {{NB_DATA{1'b0}}, b_mag};
                  end else begin
                     opnd_q <= b_mag;
                     acc_q  <= {{NB_DATA{1'b0}}, a_mag};
                  end
`ifdef MDU_DIV_EN
                  is_div_q <= op_div || op_divu;
`endif
               end else begin
                  if (op_mthi) hi_q <= i_dato_a;
                  if (op_mtlo) lo_q <= i_dato_a;
               end
            end
            S_RUN: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_W'(NB_DATA - 1)) state_q <= S_FIX;
            end
            S_FIX: begin
               hi_q    <= fix_hi_d;
               lo_q    <= fix_lo_d;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu (default 32-bit); div cases follow MDU_DIV_EN.
module tb_alu_mdu;

   localparam int N   = 32;
   localparam int LAT = N + 1;

   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;

   logic         clk = 1'b0;
   logic         rst;
   logic         valid;
   logic [1:0]   alu_op;
   logic [5:0]   funct;
   logic [N-1:0] da, db;
   logic [N-1:0] res, hi, lo;
   logic         busy, stall;

   int total = 0;
   int bad   = 0;
   logic [2*N-1:0] sb[$];
   logic [N-1:0]   m_hi, m_lo;

   typedef struct { logic [5:0] f; logic [N-1:0] a; logic [N-1:0] b; } op_t;

   alu_mdu #(.NB_DATA(N), .NB_ALU_OP(2), .NB_INSTRUCCION(6)) dut (
      .i_clk(clk), .i_reset(rst), .i_valid(valid), .i_alu_op(alu_op),
      .i_inst_funcion(funct), .i_dato_a(da), .i_dato_b(db),
      .o_resultado(res), .o_hi(hi), .o_lo(lo), .o_busy(busy), .o_stall(stall)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   function automatic logic [2*N-1:0] model(input logic [5:0] f, input logic [N-1:0] a, input logic [N-1:0] b);
      longint    p;
      int        sa, sbv;
      logic [2*N-1:0] u;
      model = '0;
      case (f)
         F_MULT:  begin p = longint'($signed(a)) * longint'($signed(b)); model = p; end
         F_MULTU: begin u = {32'b0, a} * {32'b0, b}; model = u; end
         F_DIV: begin
            sa = $signed(a); sbv = $signed(b);
            if (b == 0)                                    model = {a, 32'hFFFFFFFF};
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) model = {32'h0, 32'h80000000};
            else                                           model = {32'(sa % sbv), 32'(sa / sbv)};
         end
         F_DIVU: model = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
         default: model = '0;
      endcase
   endfunction

   task automatic drive(input logic [5:0] f, input logic [N-1:0] a, input logic [N-1:0] b);
      valid = 1'b1; alu_op = 2'b10; funct = f; da = a; db = b;
   endtask

   task automatic idle_in();
      valid = 1'b0; alu_op = 2'b00; funct = '0; da = '0; db = '0;
   endtask

   task automatic issue(input logic [5:0] f, input logic [N-1:0] a, input logic [N-1:0] b);
      @(negedge clk); drive(f, a, b);
      @(negedge clk); idle_in();
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; idle_in();
      repeat (2) @(negedge clk);
      #1;
      total++; if (hi !== '0)   begin bad++; $display("FAIL reset_hi: got %h want 0", hi); end
      total++; if (lo !== '0)   begin bad++; $display("FAIL reset_lo: got %h want 0", lo); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall); end
      total++; if (res !== '0)  begin bad++; $display("FAIL reset_res: got %h want 0", res); end
      rst = 1'b0; m_hi = '0; m_lo = '0;
   endtask

   task automatic test_move();
      issue(F_MTLO, 32'h1234, 32'h0);
      #1; m_lo = 32'h1234;
      total++; if (lo !== m_lo) begin bad++; $display("FAIL mtlo_lo: got %h want %h", lo, m_lo); end
      total++; if (hi !== m_hi) begin bad++; $display("FAIL mtlo_hi: got %h want %h", hi, m_hi); end
      issue(F_MTHI, 32'hCAFE0001, 32'h0);
      #1; m_hi = 32'hCAFE0001;
      total++; if (hi !== m_hi) begin bad++; $display("FAIL mthi_hi: got %h want %h", hi, m_hi); end
      @(negedge clk); drive(F_MFHI, '0, '0); #1;
      total++; if (res !== m_hi) begin bad++; $display("FAIL mfhi_idle: got %h want %h", res, m_hi); end
      alu_op = 2'b00; #1;
      total++; if (res !== '0) begin bad++; $display("FAIL mfhi_aluop: got %h want 0", res); end
      alu_op = 2'b10; funct = F_MFLO; #1;
      total++; if (res !== m_lo) begin bad++; $display("FAIL mflo_idle: got %h want %h", res, m_lo); end
      idle_in();
   endtask

   task automatic test_mult();
      op_t tbl[$];
      int  n;
      logic [2*N-1:0] e;
      tbl.push_back('{F_MULT,  32'hFFFFFFFE, 32'd3});
      tbl.push_back('{F_MULTU, 32'hFFFFFFFE, 32'd3});
      tbl.push_back('{F_MULT,  32'h80000000, 32'h80000000});
      tbl.push_back('{F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF});
      for (int i = 0; i < 4; i++)
         tbl.push_back('{(i % 2 == 0) ? F_MULT : F_MULTU, $urandom, $urandom});
      foreach (tbl[i]) begin
         sb.push_back(model(tbl[i].f, tbl[i].a, tbl[i].b));
         issue(tbl[i].f, tbl[i].a, tbl[i].b);
         total++; if (busy !== 1'b1) begin bad++; $display("FAIL mul_busy[%0d]: got %b want 1", i, busy); end
         wait_idle(n);
         total++; if (n != LAT) begin bad++; $display("FAIL mul_latency[%0d]: got %0d want %0d", i, n, LAT); end
         e = sb.pop_front();
         total++;
         if ({hi, lo} !== e) begin
            bad++; $display("FAIL mul_result[%0d] f=%b a=%h b=%h: got %h_%h want %h", i, tbl[i].f, tbl[i].a, tbl[i].b, hi, lo, e);
         end
         m_hi = e[2*N-1:N]; m_lo = e[N-1:0];
      end
   endtask

`ifdef MDU_DIV_EN
   task automatic test_div();
      op_t tbl[$];
      int  n;
      logic [2*N-1:0] e;
      tbl.push_back('{F_DIV,  32'hFFFFFFF9, 32'd2});
      tbl.push_back('{F_DIVU, 32'd100,      32'd7});
      tbl.push_back('{F_DIV,  32'd5,        32'd0});
      tbl.push_back('{F_DIVU, 32'hDEADBEEF, 32'd0});
      tbl.push_back('{F_DIV,  32'hFFFFFFF9, 32'd0});
      tbl.push_back('{F_DIV,  32'h80000000, 32'hFFFFFFFF});
      tbl.push_back('{F_DIV,  32'd7,        32'hFFFFFFFE});
      for (int i = 0; i < 4; i++)
         tbl.push_back('{(i % 2 == 0) ? F_DIV : F_DIVU, $urandom, $urandom_range(1, 5000)});
      foreach (tbl[i]) begin
         sb.push_back(model(tbl[i].f, tbl[i].a, tbl[i].b));
         issue(tbl[i].f, tbl[i].a, tbl[i].b);
         wait_idle(n);
         total++; if (n != LAT) begin bad++; $display("FAIL div_latency[%0d]: got %0d want %0d", i, n, LAT); end
         e = sb.pop_front();
         total++;
         if ({hi, lo} !== e) begin
            bad++; $display("FAIL div_result[%0d] f=%b a=%h b=%h: got %h_%h want %h", i, tbl[i].f, tbl[i].a, tbl[i].b, hi, lo, e);
         end
         m_hi = e[2*N-1:N]; m_lo = e[N-1:0];
      end
   endtask
`else
   task automatic test_nodiv();
      @(negedge clk); drive(F_DIVU, 32'd100, 32'd7); #1;
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL nodiv_stall: got %b want 0", stall); end
      @(negedge clk); idle_in(); #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL nodiv_busy: got %b want 0", busy); end
      total++; if (hi !== m_hi) begin bad++; $display("FAIL nodiv_hi: got %h want %h", hi, m_hi); end
      total++; if (lo !== m_lo) begin bad++; $display("FAIL nodiv_lo: got %h want %h", lo, m_lo); end
   endtask
`endif

   task automatic test_mfhi_stall();
      int n;
      logic [2*N-1:0] e;
      sb.push_back(model(F_MULT, 32'h00012345, 32'hFFFF0003));
      @(negedge clk); drive(F_MULT, 32'h00012345, 32'hFFFF0003);
      @(negedge clk); drive(F_MFHI, '0, '0); #1;
      n = 0;
      while (stall && n < 200) begin
         n++;
         @(negedge clk); #1;
      end
      e = sb.pop_front();
      total++; if (n != LAT) begin bad++; $display("FAIL mfhi_stall_cycles: got %0d want %0d", n, LAT); end
      total++; if (res !== e[2*N-1:N]) begin bad++; $display("FAIL mfhi_after_mult: got %h want %h", res, e[2*N-1:N]); end
      total++; if ({hi, lo} !== e) begin bad++; $display("FAIL mfhi_mult_result: got %h_%h want %h", hi, lo, e); end
      funct = F_MFLO; #1;
      total++; if (res !== e[N-1:0]) begin bad++; $display("FAIL mflo_after_mult: got %h want %h", res, e[N-1:0]); end
      idle_in();
      m_hi = e[2*N-1:N]; m_lo = e[N-1:0];
   endtask

   task automatic test_back_to_back();
      int n;
      logic [2*N-1:0] e;
      sb.push_back(model(F_MULT,  32'hFFFFFF00, 32'h00000101));
      sb.push_back(model(F_MULTU, 32'h89ABCDEF, 32'h76543210));
      @(negedge clk); drive(F_MULT, 32'hFFFFFF00, 32'h00000101);
      @(negedge clk); drive(F_MULTU, 32'h89ABCDEF, 32'h76543210); #1;
      n = 0;
      while (stall && n < 200) begin
         n++;
         @(negedge clk); #1;
      end
      total++; if (n != LAT) begin bad++; $display("FAIL b2b_stall_cycles: got %0d want %0d", n, LAT); end
      e = sb.pop_front();
      total++; if ({hi, lo} !== e) begin bad++; $display("FAIL b2b_first: got %h_%h want %h", hi, lo, e); end
      @(negedge clk); idle_in(); #1;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_no_gap: got %b want 1", busy); end
      wait_idle(n);
      total++; if (n != LAT) begin bad++; $display("FAIL b2b_latency: got %0d want %0d", n, LAT); end
      e = sb.pop_front();
      total++; if ({hi, lo} !== e) begin bad++; $display("FAIL b2b_second: got %h_%h want %h", hi, lo, e); end
      m_hi = e[2*N-1:N]; m_lo = e[N-1:0];
   endtask

   task automatic test_reset_abort();
      issue(F_MULT, 32'h7FFFFFFF, 32'h7FFFFFFF);
      repeat (9) @(negedge clk);
      #1;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_pre_busy: got %b want 1", busy); end
      rst = 1'b1; #1;
      total++; if ({hi, lo} !== '0) begin bad++; $display("FAIL abort_hilo: got %h_%h want 0", hi, lo); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
      @(negedge clk); rst = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_idle: got %b want 0", busy); end
      total++; if ({hi, lo} !== '0) begin bad++; $display("FAIL abort_nowrite: got %h_%h want 0", hi, lo); end
   endtask

   initial begin
      rst = 1'b1;
      idle_in();
      test_reset();
      test_move();
      test_mult();
`ifdef MDU_DIV_EN
      test_div();
`else
      test_nodiv();
`endif
      test_mfhi_stall();
      test_back_to_back();
      test_reset_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
